// File: rtl/tdm_demux8_rx.sv
// Receive side of the 8:1 slot-multiplexed link: gathers slots 0..7 into shadow registers and
// publishes the whole frame at once. Define TDM_PARITY_EN to add a 9th even-parity slot.
module tdm_demux8_rx #(
   parameter int unsigned WIDTH = 1
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               in_valid,
   input  logic               frame_start,
   input  logic [WIDTH-1:0]   din,
`ifdef TDM_PARITY_EN
   output logic [3:0]         slot,
   output logic               parity_err,
`else
   output logic [2:0]         slot,
`endif
   output logic [8*WIDTH-1:0] d_out,
   output logic               frame_valid,
   output logic               frame_err
);

`ifdef TDM_PARITY_EN
   localparam int unsigned SW = 4;
`else
   localparam int unsigned SW = 3;
`endif

   typedef enum logic [0:0] {StIdle, StRecv} state_e;

   state_e                       state_q, state_d;
   logic [SW-1:0]                slot_q, slot_d;
   logic [7:0][WIDTH-1:0]        shadow_q, shadow_d;
   logic [8*WIDTH-1:0]           dout_q, dout_d;
   logic                         fv_q, fv_d;
   logic                         fe_q, fe_d;
   logic                         pe_q, pe_d;

   always_comb begin
      state_d  = state_q;
      slot_d   = slot_q;
      shadow_d = shadow_q;
      dout_d   = dout_q;
      fv_d     = 1'b0;
      fe_d     = 1'b0;
      pe_d     = 1'b0;
      if (in_valid) begin
         if (frame_start) begin
            // Slot 0 always (re)starts a frame; mid-frame it drops the partial frame.
            shadow_d[0] = din;
            slot_d      = SW'(1);
            state_d     = StRecv;
            fe_d        = (state_q == StRecv);
         end else if (state_q == StRecv) begin
`ifdef TDM_PARITY_EN
            if (slot_q == SW'(8)) begin
               slot_d  = '0;
               state_d = StIdle;
               if (din[0] == ^shadow_q) begin
                  dout_d = shadow_q;
                  fv_d   = 1'b1;
               end else begin
                  pe_d = 1'b1;
               end
            end else begin
               shadow_d[slot_q[2:0]] = din;
               slot_d                = slot_q + 1'b1;
            end
`else
            shadow_d[slot_q] = din;
            slot_d           = slot_q + 1'b1;
            if (slot_q == 3'd7) begin
               dout_d  = shadow_d;
               fv_d    = 1'b1;
               state_d = StIdle;
            end
`endif
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= StIdle;
         slot_q   <= '0;
         shadow_q <= '0;
         dout_q   <= '0;
         fv_q     <= 1'b0;
         fe_q     <= 1'b0;
         pe_q     <= 1'b0;
      end else begin
         state_q  <= state_d;
         slot_q   <= slot_d;
         shadow_q <= shadow_d;
         dout_q   <= dout_d;
         fv_q     <= fv_d;
         fe_q     <= fe_d;
         pe_q     <= pe_d;
      end
   end

   assign slot        = slot_q;
   assign d_out       = dout_q;
   assign frame_valid = fv_q;
   assign frame_err   = fe_q;
`ifdef TDM_PARITY_EN
   assign parity_err  = pe_q;
`else
   logic unused_pe;
   assign unused_pe = pe_q;
`endif

endmodule

// File: tb/tb_tdm_demux8_rx.sv
// Self-checking bench for tdm_demux8_rx: directed and random frames against a sample-count model.
module tb_tdm_demux8_rx;
   localparam int unsigned W = 1;
`ifdef TDM_PARITY_EN
   localparam int unsigned SW = 4;
`else
   localparam int unsigned SW = 3;
`endif

   logic               clk = 1'b0;
   logic               rst;
   logic               in_valid;
   logic               frame_start;
   logic [W-1:0]       din;
   logic [SW-1:0]      slot;
   logic [8*W-1:0]     d_out;
   logic               frame_valid;
   logic               frame_err;
`ifdef TDM_PARITY_EN
   logic               parity_err;
`endif

   tdm_demux8_rx #(.WIDTH(W)) dut (
      .clk         (clk),
      .rst         (rst),
      .in_valid    (in_valid),
      .frame_start (frame_start),
      .din         (din),
`ifdef TDM_PARITY_EN
      .parity_err  (parity_err),
`endif
      .slot        (slot),
      .d_out       (d_out),
      .frame_valid (frame_valid),
      .frame_err   (frame_err)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int fails  = 0;

   // Model: n = samples accepted in the current frame (0 means waiting for slot 0).
   int             n;
   logic [W-1:0]   mbuf [8];
   logic [8*W-1:0] m_dout;
   bit             m_fv, m_fe, m_pe;

   task automatic chk(string tag, logic [127:0] obs, logic [127:0] exp);
      checks++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [8*W-1:0] packed_buf();
      logic [8*W-1:0] r;
      for (int k = 0; k < 8; k++) r[k*W +: W] = mbuf[k];
      return r;
   endfunction

   task automatic model_step(bit v, bit fs, logic [W-1:0] d);
      m_fv = 0; m_fe = 0; m_pe = 0;
      if (!v) return;
      if (fs) begin
         m_fe    = (n > 0);
         mbuf[0] = d;
         n       = 1;
      end else if (n > 0) begin
         if (n < 8) begin
            mbuf[n] = d;
            n++;
`ifndef TDM_PARITY_EN
            if (n == 8) begin
               m_dout = packed_buf();
               m_fv   = 1;
               n      = 0;
            end
`endif
         end else begin
            if (d[0] == ^packed_buf()) begin
               m_dout = packed_buf();
               m_fv   = 1;
            end else begin
               m_pe = 1;
            end
            n = 0;
         end
      end
   endtask

   task automatic check_outputs();
      chk("frame_valid", frame_valid, m_fv);
      chk("frame_err", frame_err, m_fe);
      chk("d_out", d_out, m_dout);
      chk("slot", slot, n);
`ifdef TDM_PARITY_EN
      chk("parity_err", parity_err, m_pe);
`endif
   endtask

   task automatic step(bit v, bit fs, logic [W-1:0] d);
      @(negedge clk);
      in_valid    = v;
      frame_start = fs;
      din         = d;
      model_step(v, fs, d);
      @(posedge clk);
      #1;
      check_outputs();
   endtask

   task automatic gap(int cycles);
      for (int i = 0; i < cycles; i++) step(0, W'($urandom), W'($urandom));
   endtask

   // Sends slots 0..7 of val (plus parity slot when enabled, inverted if corrupt).
   task automatic send_frame(logic [8*W-1:0] val, int max_gap, bit corrupt);
      for (int k = 0; k < 8; k++) begin
         step(1, k == 0, val[k*W +: W]);
         if (max_gap > 0) gap($urandom_range(max_gap));
      end
`ifdef TDM_PARITY_EN
      step(1, 0, W'(^val ^ corrupt));
`else
      if (corrupt) gap(0);
`endif
   endtask

   initial begin
      rst = 1'b1; in_valid = 0; frame_start = 0; din = '0;
      n = 0; m_dout = '0; m_fv = 0; m_fe = 0; m_pe = 0;
      for (int k = 0; k < 8; k++) mbuf[k] = '0;
      #12;
      check_outputs();
      @(negedge clk);
      rst = 1'b0;

      // Directed frame 1,0,1,1,0,0,1,0
      send_frame(8'h4D, 0, 0);
      chk("tp1_dout", d_out, 8'h4D);
      gap(1);

      // Same frame with a 3-cycle gap between slots 3 and 4
      for (int k = 0; k < 4; k++) step(1, k == 0, W'(8'h4D >> k));
      gap(3);
      chk("tp2_slot_hold", slot, 4);
      for (int k = 4; k < 8; k++) step(1, 0, W'(8'h4D >> k));
`ifdef TDM_PARITY_EN
      step(1, 0, W'(^8'h4D));
`endif
      chk("tp2_dout", d_out, 8'h4D);

      // Resync at slot 5, then full 0xA5 frame
      for (int k = 0; k < 5; k++) step(1, k == 0, W'(8'h33 >> k));
      step(1, 1, W'(1));
      chk("tp3_err", frame_err, 1'b1);
      chk("tp3_dout_kept", d_out, 8'h4D);
      for (int k = 1; k < 8; k++) step(1, 0, W'(8'hA5 >> k));
`ifdef TDM_PARITY_EN
      step(1, 0, W'(^8'hA5));
`endif
      chk("tp3_dout", d_out, 8'hA5);

      // Back-to-back FF then 00
      send_frame(8'hFF, 0, 0);
      chk("tp4_ff", d_out, 8'hFF);
      send_frame(8'h00, 0, 0);
      chk("tp4_00", d_out, 8'h00);

      // Reset after slot 3, then a 3C frame
      for (int k = 0; k < 4; k++) step(1, k == 0, W'(8'h5A >> k));
      @(negedge clk);
      in_valid = 0;
      rst = 1'b1;
      n = 0; m_dout = '0; m_fv = 0; m_fe = 0; m_pe = 0;
      #1;
      check_outputs();
      @(negedge clk);
      rst = 1'b0;
      gap(2);
      send_frame(8'h3C, 0, 0);
      chk("tp5_dout", d_out, 8'h3C);

`ifdef TDM_PARITY_EN
      send_frame(8'h01, 0, 0);
      chk("tp6_good", d_out, 8'h01);
      send_frame(8'h01, 0, 1);
      chk("tp6_perr", parity_err, 1'b1);
      chk("tp6_dout_kept", d_out, 8'h01);
`endif

      // Random traffic: idle junk, gaps, resyncs, parity corruption
      for (int f = 0; f < 60; f++) begin
         logic [8*W-1:0] v;
         v = 8'($urandom);
         if ($urandom_range(3) == 0) step(1, 0, W'($urandom));
         if ($urandom_range(4) == 0) begin
            for (int k = 0; k < int'($urandom_range(1, 7)); k++) step(1, k == 0, W'($urandom));
         end
         send_frame(v, $urandom_range(1), $urandom_range(5) == 0);
         gap($urandom_range(1));
      end

      $display("%0d/%0d checks passed", checks - fails, checks);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end
endmodule

// File: doc/tdm_demux8_rx.md
Name: tdm_demux8_rx

Overview:
- Receive side of the 8:1 slot-multiplexed link. The transmit end drives channel samples D0..D7 onto one line in slot order Sel=0..7.
- This block tracks the slot counter and captures each sample into a shadow register for its channel.
- When a frame completes, it presents all 8 channels in parallel at once.
- Sits between the serial link input and per-channel consumer logic.

Parameters:
- WIDTH, 1, bits per channel sample. Legal range 1..16.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous reset, active-high
- in_valid  input  1  din carries a slot sample this cycle
- frame_start  input  1  qualifies din as slot 0; ignored when in_valid=0
- din  input  WIDTH  serial slot sample
- slot  output  3  slot index expected for the next valid sample
- d_out  output  8*WIDTH  parallel frame; channel k at bits [k*WIDTH +: WIDTH]
- frame_valid  output  1  one-cycle pulse; d_out was updated this cycle
- frame_err  output  1  one-cycle pulse; frame_start arrived mid-frame

Behaviour:
- Reset values (async on rst=1): state=IDLE, slot=0, shadow=0, d_out=0, frame_valid=0, frame_err=0.
- States:
  - IDLE: waiting for slot 0.
  - RECV: slots 1..7 pending.
- IDLE:
  - in_valid & frame_start: shadow[0]<=din; slot<=1; go to RECV.
  - in_valid without frame_start: sample discarded; no error; stay in IDLE.
- RECV, in_valid & !frame_start:
  - shadow[slot]<=din; slot<=slot+1.
  - If slot==7: d_out<={din, shadow[6:0]} in the same edge; frame_valid=1 next cycle; slot wraps to 0; go to IDLE.
- RECV, in_valid & frame_start (resync):
  - frame_err=1 for one cycle.
  - Partial frame dropped; d_out unchanged.
  - shadow[0]<=din; slot<=1; stay in RECV.
- in_valid=0 in any state: all state holds. Gaps between slots are unlimited.
- Latency: frame_valid and new d_out are visible in the cycle after the edge that captured slot 7.
- d_out holds its value until the next complete frame.
- Back-to-back frames are legal: frame_start with slot 0 on the cycle right after slot 7 gives no bubble. frame_valid of the previous frame and the capture of the new slot 0 coincide.
- Shadow registers are not cleared between frames; only slots written in the current frame reach d_out.
- rst mid-frame: partial frame is lost; outputs return to reset values at once.
- frame_valid and frame_err are never both 1 in the same cycle.

Optional Feature:
- Macro: TDM_PARITY_EN.
- When defined:
  - A 9th slot (slot=8; slot widens to 4 bits) carries even parity: the XOR-reduce of all 8*WIDTH data bits, sent in din[0].
  - The frame completes on the parity slot, not slot 7.
  - Parity match: d_out updates and frame_valid pulses.
  - Parity mismatch: d_out is unchanged; the extra output parity_err (1 bit, reset 0) pulses for one cycle; state returns to IDLE.
- When undefined: no parity slot, no parity_err port, slot is 3 bits. Behaviour is exactly as above.

Test Plan:
- Reset then frame with WIDTH=1, din=1,0,1,1,0,0,1,0 on slots 0..7 (frame_start on the first) -> frame_valid one cycle after the 8th sample; d_out=8'b01001101.
- Same frame with in_valid low for 3 cycles between slots 3 and 4 -> identical d_out; frame_valid asserts only after slot 7; slot holds at 4 during the gap.
- frame_start at slot 5 of a partial frame, followed by a full frame of 0xA5 pattern -> frame_err one pulse; d_out keeps the previous frame until the new frame completes with 8'hA5.
- Two back-to-back frames 8'hFF then 8'h00, no idle cycle -> two frame_valid pulses 8 cycles apart; d_out=FF then 00.
- rst asserted after slot 3, released, then a full frame 8'h3C -> outputs 0 during reset; no frame_valid from the partial frame; d_out=8'h3C after the new frame.
- With TDM_PARITY_EN, frame 8'h01 sent with parity 1, then the same frame with parity 0 -> frame_valid with d_out=01; then parity_err pulse with d_out still 01.
